// File: rtl/text_pkg.sv
// Shared types, cell geometry and the 5x8 font table for the text-line renderer.
package text_pkg;

  localparam int CHAR_W = 5;
  localparam int CHAR_H = 8;
  localparam int CELL_W = 6;

  typedef logic [7:0] char_t;
  typedef logic [CHAR_W-1:0] glyph_row_t;

  // Glyphs are drawn leftmost-first below; the result is flipped so bit 0 is the leftmost pixel.
  function automatic glyph_row_t font_row(input char_t code, input logic [2:0] row);
    logic [39:0] g;
    logic [39:0] sh;
    case (code)
      8'h30:   g = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110, 5'b00000};
      8'h31:   g = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110, 5'b00000};
      8'h32:   g = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111, 5'b00000};
      8'h33:   g = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110, 5'b00000};
      8'h34:   g = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010, 5'b00000};
      8'h35:   g = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110, 5'b00000};
      8'h36:   g = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110, 5'b00000};
      8'h37:   g = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
      8'h38:   g = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b00000};
      8'h39:   g = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100, 5'b00000};
      default: g = 40'd0;
    endcase
    sh = g << ({3'd0, row} * 6'd5);
    return {sh[35], sh[36], sh[37], sh[38], sh[39]};
  endfunction

endpackage

// File: rtl/char_font_rom.sv
// Combinational glyph-row lookup: (code, row) -> 5 pixels, bit 0 leftmost.
module char_font_rom
  import text_pkg::*;
(
  input  logic [7:0]        code,
  input  logic [2:0]        row,
  output logic [CHAR_W-1:0] bits
);

  assign bits = font_row(code, row);

endmodule

// File: rtl/show_text_line.sv
// Framed, double-buffered line of NUM_CHARS scaled 5x8 glyphs driven by VGA visible counters.
// Define SHOW_TEXT_CURSOR_EN to add a blinking inverse-video cursor and the cursor_pos port.
module show_text_line
  import text_pkg::*;
#(
  parameter int NUM_CHARS = 8,
  parameter int SCALE     = 4,
  parameter int X_LOC     = 70,
  parameter int Y_LOC     = 150,
  parameter int HC_W      = 10,
  parameter int VC_W      = 10,
  parameter int BLINK_FR  = 30,
  localparam int IW       = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [HC_W-1:0] hc_visible,
  input  logic [VC_W-1:0] vc_visible,
  input  logic            frame_sync,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [7:0]      wr_char,
  input  logic            commit,
`ifdef SHOW_TEXT_CURSOR_EN
  input  logic [IW-1:0]   cursor_pos,
`endif
  output logic            busy,
  output logic            in_square,
  output logic            in_character
);

  localparam int BOX_W = (CELL_W * NUM_CHARS + 1) * SCALE;
  localparam int BOX_H = (CHAR_H + 1) * SCALE;
  localparam logic [HC_W-1:0] BX0 = HC_W'(X_LOC);
  localparam logic [HC_W-1:0] BX1 = HC_W'(X_LOC + BOX_W);
  localparam logic [HC_W-1:0] TX0 = HC_W'(X_LOC + SCALE);
  localparam logic [HC_W-1:0] XE  = HC_W'(X_LOC + BOX_W - 1);
  localparam logic [VC_W-1:0] BY0 = VC_W'(Y_LOC);
  localparam logic [VC_W-1:0] BY1 = VC_W'(Y_LOC + BOX_H);
  localparam logic [VC_W-1:0] TY0 = VC_W'(Y_LOC + SCALE);
  localparam logic [2:0]      SUB_LAST = 3'(SCALE - 1);
  localparam logic [2:0]      COL_LAST = 3'(CELL_W - 1);
  localparam logic [2:0]      ROW_LAST = 3'(CHAR_H - 1);
  localparam logic [IW-1:0]   CHR_LAST = IW'(NUM_CHARS - 1);

  char_t front_q [NUM_CHARS];
  char_t front_d [NUM_CHARS];
  char_t back_q  [NUM_CHARS];
  char_t back_d  [NUM_CHARS];
  logic          busy_q, busy_d;
  logic [2:0]    sub_x_q, sub_x_d, col_q, col_d, sub_y_q, sub_y_d, row_q, row_d;
  logic [IW-1:0] chr_q, chr_d;
  logic          in_square_q, in_square_d, in_character_q, in_character_d;
  logic          in_tx_s, in_ty_s, bit_s, pix_s;
  glyph_row_t    glyph_s;

  assign in_tx_s = (hc_visible >= TX0) && (hc_visible < BX1);
  assign in_ty_s = (vc_visible >= TY0) && (vc_visible < BY1);

  // A swap needs busy already set, so a commit on a frame_sync edge waits for the next frame_sync.
  always_comb begin
    front_d = front_q;
    back_d  = back_q;
    busy_d  = busy_q;
    if (wr_en && !busy_q && (int'(wr_idx) < NUM_CHARS)) begin
      back_d[wr_idx] = wr_char;
    end else begin
      back_d = back_q;
    end
    if (busy_q) begin
      if (frame_sync) begin
        front_d = back_q;
        busy_d  = 1'b0;
      end else begin
        busy_d  = 1'b1;
      end
    end else begin
      busy_d = commit;
    end
  end

  always_comb begin
    sub_x_d = sub_x_q;
    col_d   = col_q;
    chr_d   = chr_q;
    if (!in_tx_s) begin
      sub_x_d = 3'd0;
      col_d   = 3'd0;
      chr_d   = IW'(0);
    end else if (sub_x_q != SUB_LAST) begin
      sub_x_d = sub_x_q + 3'd1;
    end else begin
      sub_x_d = 3'd0;
      if (col_q != COL_LAST) begin
        col_d = col_q + 3'd1;
      end else begin
        col_d = 3'd0;
        chr_d = (chr_q == CHR_LAST) ? IW'(0) : chr_q + IW'(1);
      end
    end
  end

  always_comb begin
    sub_y_d = sub_y_q;
    row_d   = row_q;
    if (!in_ty_s) begin
      sub_y_d = 3'd0;
      row_d   = 3'd0;
    end else if (hc_visible == XE) begin
      if (sub_y_q != SUB_LAST) begin
        sub_y_d = sub_y_q + 3'd1;
      end else begin
        sub_y_d = 3'd0;
        row_d   = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;
      end
    end else begin
      sub_y_d = sub_y_q;
      row_d   = row_q;
    end
  end

  char_font_rom u_font (
    .code (front_q[chr_q]),
    .row  (row_q),
    .bits (glyph_s)
  );

`ifdef SHOW_TEXT_CURSOR_EN
  localparam int BW = $clog2(BLINK_FR + 1);
  logic [BW-1:0] fcnt_q, fcnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (!frame_sync) begin
      fcnt_d = fcnt_q;
    end else if (fcnt_q == BW'(BLINK_FR - 1)) begin
      fcnt_d  = BW'(0);
      blink_d = ~blink_q;
    end else begin
      fcnt_d = fcnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt_q  <= BW'(0);
      blink_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
    end
  end
`endif

  always_comb begin
    if (col_q == COL_LAST) begin
      bit_s = 1'b0;
    end else begin
      bit_s = glyph_s[col_q];
    end
    pix_s = bit_s;
`ifdef SHOW_TEXT_CURSOR_EN
    if (blink_q && (chr_q == cursor_pos) && (col_q != COL_LAST)) begin
      pix_s = ~bit_s;
    end else begin
      pix_s = bit_s;
    end
`endif
    in_square_d    = (hc_visible >= BX0) && (hc_visible < BX1) &&
                     (vc_visible >= BY0) && (vc_visible < BY1);
    in_character_d = in_tx_s && in_ty_s && pix_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      front_q        <= '{default: 8'h20};
      back_q         <= '{default: 8'h20};
      busy_q         <= 1'b0;
      sub_x_q        <= 3'd0;
      col_q          <= 3'd0;
      chr_q          <= IW'(0);
      sub_y_q        <= 3'd0;
      row_q          <= 3'd0;
      in_square_q    <= 1'b0;
      in_character_q <= 1'b0;
    end else begin
      front_q        <= front_d;
      back_q         <= back_d;
      busy_q         <= busy_d;
      sub_x_q        <= sub_x_d;
      col_q          <= col_d;
      chr_q          <= chr_d;
      sub_y_q        <= sub_y_d;
      row_q          <= row_d;
      in_square_q    <= in_square_d;
      in_character_q <= in_character_d;
    end
  end

  assign busy         = busy_q;
  assign in_square    = in_square_q;
  assign in_character = in_character_q;

endmodule

// File: tb/tb_show_text_line.sv
// Directed self-checking bench for show_text_line (NUM_CHARS=8, SCALE=4, box at 70,150).
module tb_show_text_line;

  localparam int N = 8, S = 4, XL = 70, YL = 150;
  localparam int BOX_W = (6 * N + 1) * S;
  localparam int BOX_H = 9 * S;
  localparam int TX0 = XL + S, TY0 = YL + S;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] hc = 10'd0, vc = 10'd0;
  logic       frame_sync = 1'b0, wr_en = 1'b0, commit = 1'b0;
  logic [2:0] wr_idx = 3'd0;
  logic [7:0] wr_char = 8'h20;
  logic       busy, in_square, in_character;
`ifdef SHOW_TEXT_CURSOR_EN
  logic [2:0] cursor_pos = 3'd2;
`endif

  int checks = 0, failures = 0;
  int fs_count = 0;
  logic [7:0] exp_front [N];

  always #5 clk = ~clk;

  show_text_line #(.NUM_CHARS(N), .SCALE(S), .X_LOC(XL), .Y_LOC(YL),
                   .HC_W(10), .VC_W(10), .BLINK_FR(2)) dut (
    .clk(clk), .rst(rst), .hc_visible(hc), .vc_visible(vc), .frame_sync(frame_sync),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char), .commit(commit),
`ifdef SHOW_TEXT_CURSOR_EN
    .cursor_pos(cursor_pos),
`endif
    .busy(busy), .in_square(in_square), .in_character(in_character)
  );

  function automatic logic [39:0] font(input logic [7:0] c);
    case (c)
      8'h30:   return {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110, 5'b00000};
      8'h31:   return {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110, 5'b00000};
      8'h32:   return {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111, 5'b00000};
      8'h33:   return {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110, 5'b00000};
      8'h37:   return {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000, 5'b00000};
      8'h39:   return {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100, 5'b00000};
      default: return 40'd0;
    endcase
  endfunction

  function automatic logic exp_sq(input int h, input int v);
    return (h >= XL) && (h < XL + BOX_W) && (v >= YL) && (v < YL + BOX_H);
  endfunction

  function automatic logic exp_char(input int h, input int v);
    int x, y, ci, col, row;
    logic [39:0] g;
    logic b;
    x = h - TX0;
    y = v - TY0;
    if (x < 0 || x >= 6 * N * S || y < 0 || y >= 8 * S) return 1'b0;
    ci  = x / (6 * S);
    col = (x / S) % 6;
    row = y / S;
    g   = font(exp_front[ci]);
    b   = (col < 5) ? g[39 - row * 5 - col] : 1'b0;
`ifdef SHOW_TEXT_CURSOR_EN
    if (((fs_count / 2) % 2) == 1 && ci == 2 && col < 5) b = ~b;
`endif
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int v0, input int v1, output int bad, output int fh, output int fv);
    bad = 0; fh = -1; fv = -1;
    for (int v = v0; v <= v1; v++) begin
      for (int h = 60; h <= 275; h++) begin
        hc = 10'(h); vc = 10'(v);
        tick();
        if (in_square !== exp_sq(h, v) || in_character !== exp_char(h, v)) begin
          if (bad == 0) begin fh = h; fv = v; end
          bad++;
        end
      end
    end
    hc = 10'd0; vc = 10'd0;
  endtask

  task automatic wr(input int idx, input logic [7:0] ch, input logic with_commit);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_char = ch; commit = with_commit;
    tick();
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic pulse(input logic c, input logic fs);
    commit = c; frame_sync = fs;
    tick();
    commit = 1'b0; frame_sync = 1'b0;
    if (fs) fs_count++;
  endtask

  task automatic test_reset();
    int bad, fh, fv;
    int hs [5] = '{69, 70, 265, 266, 70};
    int vs [5] = '{150, 150, 185, 185, 186};
    logic ex [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rst = 1'b0; hc = 10'd100; vc = 10'd160;
    tick();
    checks++; if (in_square !== 1'b0) begin failures++; $display("FAIL reset_in_square got=%b exp=0", in_square); end
    checks++; if (in_character !== 1'b0) begin failures++; $display("FAIL reset_in_character got=%b exp=0", in_character); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b1; fs_count = 0;
    for (int i = 0; i < N; i++) exp_front[i] = 8'h20;
    for (int i = 0; i < 5; i++) begin
      hc = 10'(hs[i]); vc = 10'(vs[i]);
      tick();
      checks++;
      if (in_square !== ex[i]) begin
        failures++; $display("FAIL box_edge h=%0d v=%0d got=%b exp=%b", hs[i], vs[i], in_square, ex[i]);
      end
    end
    scan(146, 190, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL blank_frame mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
  endtask

  task automatic test_write_commit();
    int bad, fh, fv;
    for (int i = 0; i < 4; i++) wr(i, 8'(8'h30 + i), 1'b0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_before_commit got=%b exp=0", busy); end
    pulse(1'b1, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_commit got=%b exp=1", busy); end
    scan(152, 158, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL pre_swap_front mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
    pulse(1'b0, 1'b1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_swap got=%b exp=0", busy); end
    exp_front[0] = 8'h30; exp_front[1] = 8'h31; exp_front[2] = 8'h32; exp_front[3] = 8'h33;
    hc = 10'd60; vc = 10'd153;
    tick();
    for (int h = 70; h <= 95; h++) begin
      hc = 10'(h); vc = 10'd154;
      tick();
      checks++;
      if (in_character !== ((h >= 78 && h <= 89) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL glyph0_row0 h=%0d got=%b exp=%b", h, in_character, (h >= 78 && h <= 89));
      end
    end
    scan(152, 158, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL text_0123 mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
  endtask

  task automatic test_busy_drop();
    int bad, fh, fv;
    pulse(1'b1, 1'b0);
    wr(0, 8'h37, 1'b0);
    pulse(1'b0, 1'b1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_drop_swap got=%b exp=0", busy); end
    scan(152, 158, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL dropped_write mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
    wr(1, 8'h37, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    exp_front[1] = 8'h37;
    scan(152, 158, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL partial_edit mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
  endtask

  task automatic test_commit_with_sync();
    int bad, fh, fv;
    wr(2, 8'h37, 1'b0);
    pulse(1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL commit_sync_busy got=%b exp=1", busy); end
    scan(152, 158, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL front_held mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
    pulse(1'b0, 1'b1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL second_sync_busy got=%b exp=0", busy); end
    exp_front[2] = 8'h37;
    scan(152, 158, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL second_swap mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
  endtask

  task automatic test_back_to_back();
    int bad, fh, fv;
    wr(3, 8'h39, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_commit_busy got=%b exp=1", busy); end
    pulse(1'b0, 1'b1);
    exp_front[3] = 8'h39;
    scan(152, 158, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL wr_commit_text mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
  endtask

  task automatic test_reset_mid_line();
    int bad, fh, fv;
    pulse(1'b1, 1'b0);
    scan(148, 159, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL pre_reset_text mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
    for (int h = 60; h < 100; h++) begin
      hc = 10'(h); vc = 10'd160;
      tick();
    end
    hc = 10'd100; rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (in_square !== 1'b0) begin failures++; $display("FAIL mid_reset_in_square got=%b exp=0", in_square); end
    checks++; if (in_character !== 1'b0) begin failures++; $display("FAIL mid_reset_in_character got=%b exp=0", in_character); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    fs_count = 0;
    for (int i = 0; i < N; i++) exp_front[i] = 8'h20;
    scan(146, 190, bad, fh, fv);
    checks++; if (bad !== 0) begin failures++; $display("FAIL post_reset_blank mismatches=%0d exp=0 first h=%0d v=%0d", bad, fh, fv); end
  endtask

`ifdef SHOW_TEXT_CURSOR_EN
  task automatic test_cursor();
    int bad, fh, fv;
    for (int f = 0; f < 6; f++) begin
      hc = 10'd60; vc = 10'd153;
      tick();
      for (int h = 70; h <= 122; h++) begin
        hc = 10'(h); vc = 10'd154;
        tick();
      end
      checks++;
      if (in_character !== ((f == 2 || f == 3) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL cursor_cell frame=%0d got=%b exp=%b", f, in_character, (f == 2 || f == 3));
      end
      scan(152, 158, bad, fh, fv);
      checks++; if (bad !== 0) begin failures++; $display("FAIL cursor_frame%0d mismatches=%0d exp=0 first h=%0d v=%0d", f, bad, fh, fv); end
      pulse(1'b0, 1'b1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_commit();
    test_busy_drop();
    test_commit_with_sync();
    test_back_to_back();
    test_reset_mid_line();
`ifdef SHOW_TEXT_CURSOR_EN
    test_cursor();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
